nibble_add_seq: RTL

NIBBLE_ADD_SEQ -- requirements
Module: nibble_add_seq

---
 rtl/nibble_add_pkg.sv | 14 +
 rtl/adder4bits.sv | 26 ++
 rtl/nibble_add_seq.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/nibble_add_pkg.sv
// nibble_add_pkg -- shared types and constants for the nibble-serial adder.
//   NIB_W   : width of one arithmetic slice (the shared adder width)
//   state_t : control FSM encoding (IDLE / RUN / DONE)
package nibble_add_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder4bits.sv
// adder4bits -- 4-bit ripple-carry adder, purely combinational.
// Ports:
//   a, b : 4-bit addends
//   ci   : carry-in
//   s    : 4-bit sum
//   co   : carry-out of bit 3
module adder4bits (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[4];

endmodule

// File: rtl/nibble_add_seq.sv
// nibble_add_seq -- sequential W-bit adder that processes one 4-bit slice per
// clock through a single shared adder4bits instance.
// Parameters:
//   NIBBLES : slices per operand (1..8); W = 4*NIBBLES
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   start : request an operation (only honoured in IDLE)
//   a, b  : W-bit operands, captured on accepted start
//   cin   : carry-in to slice 0, captured on accepted start
//   sub   : (only with NIBBLE_ADD_SUB_EN) 1 = compute a - b, captured on start
//   busy  : high in RUN and DONE
//   done  : one-cycle pulse, sum/cout valid
//   sum   : W-bit registered result
//   cout  : registered carry-out of the top slice
// Optional feature: define NIBBLE_ADD_SUB_EN to add the sub port.
// A result's done pulse appears NIBBLES+1 rising edges after start is presented,
// counting the accepting edge.
module nibble_add_seq
  import nibble_add_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [NIB_W*NIBBLES-1:0] a,
  input  logic [NIB_W*NIBBLES-1:0] b,
  input  logic                     cin,
`ifdef NIBBLE_ADD_SUB_EN
  input  logic                     sub,
`endif
  output logic                     busy,
  output logic                     done,
  output logic [NIB_W*NIBBLES-1:0] sum,
  output logic                     cout
);

  localparam int W     = NIB_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [W-1:0]       a_q, b_q;
  logic               carry_q;
  logic [W-1:0]       sum_q;
  logic               cout_q;
  logic               sub_q;
  logic               sub_in;

  logic               accept;
  logic               last;
  logic [NIB_W-1:0]   slice_a, slice_b, slice_s;
  logic               slice_co;

  assign accept = (state_q == IDLE) && start;
  assign last   = (idx_q == IDX_W'(NIBBLES - 1));

`ifdef NIBBLE_ADD_SUB_EN
  assign sub_in = sub;

  always_ff @(posedge clk) begin
    if (rst)         sub_q <= 1'b0;
    else if (accept) sub_q <= sub;
  end
`else
  assign sub_in = 1'b0;
  assign sub_q  = 1'b0;
`endif

  // Control FSM: state register.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; the reset is synchronous, so it lives inside the clocked
  // branch rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Control FSM: next-state logic.
  // NOTE: state_d is assigned before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  // Operand capture.
  // NOTE: a_q/b_q carry no reset: they are only read in RUN, which is always
  // entered through a capture, so a reset would add logic for no behaviour.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= b;
    end
  end

  // Slice selection; subtraction feeds the one's complement of B and relies
  // on the initial carry of 1 to complete the two's complement.
  assign slice_a = a_q[NIB_W*idx_q +: NIB_W];
  assign slice_b = b_q[NIB_W*idx_q +: NIB_W] ^ {NIB_W{sub_q}};

  adder4bits u_adder (
    .a  (slice_a),
    .b  (slice_b),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  // Datapath: slice index, ripple carry between cycles, result registers.
  // sum is not cleared on start: unwritten slices keep the previous result.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else if (accept) begin
      idx_q   <= '0;
      carry_q <= sub_in ? 1'b1 : cin;
    end else if (state_q == RUN) begin
      sum_q[NIB_W*idx_q +: NIB_W] <= slice_s;
      carry_q                     <= slice_co;
      idx_q                       <= idx_q + IDX_W'(1);
      if (last) cout_q <= slice_co;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
